// File: rtl/gcn_index_sequencer.sv
// Row/column index sequencer: sweeps ROWS x COLS read indices under ready backpressure and
// replays each accepted index READ_LATENCY cycles later as a write index. Optional GCN_SEQ_STALL_COUNT_EN adds stall_count.
module gcn_index_sequencer #(
  parameter int ROWS         = 6,
  parameter int COLS         = 3,
  parameter int READ_LATENCY = 2,
  parameter int ROW_W        = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int COL_W        = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             col_major,
  input  logic             rd_ready,
  output logic             busy,
  output logic             done,
  output logic             rd_valid,
  output logic [ROW_W-1:0] rd_row,
  output logic [COL_W-1:0] rd_col,
  output logic             rd_last,
  output logic             wr_valid,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col
`ifdef GCN_SEQ_STALL_COUNT_EN
  ,
  output logic [15:0]      stall_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

  state_t state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             mode_q, mode_d;
  logic [READ_LATENCY-1:0]            vld_pipe_q, vld_pipe_d;
  logic [READ_LATENCY-1:0][ROW_W-1:0] row_pipe_q, row_pipe_d;
  logic [READ_LATENCY-1:0][COL_W-1:0] col_pipe_q, col_pipe_d;
  logic accept, at_last, pend;

  assign accept  = (state_q == RUN) && rd_ready;
  assign at_last = (row_q == ROW_MAX) && (col_q == COL_MAX);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    mode_d  = mode_q;
    // The final stage is on the write port this cycle; only earlier stages keep DRAIN alive.
    pend = 1'b0;
    for (int i = 0; i < READ_LATENCY - 1; i++) pend = pend | vld_pipe_q[i];
    case (state_q)
      IDLE: begin
        row_d = '0;
        col_d = '0;
        if (start) begin
          state_d = RUN;
          mode_d  = col_major;
        end
      end
      RUN: begin
        if (accept) begin
          if (at_last) begin
            state_d = DRAIN;
            row_d   = '0;
            col_d   = '0;
          end else if (!mode_q) begin
            if (col_q == COL_MAX) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else begin
            if (row_q == ROW_MAX) begin
              row_d = '0;
              col_d = col_q + COL_W'(1);
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end
        end
      end
      DRAIN:   if (!pend) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_pipe_d    = '0;
    row_pipe_d    = '0;
    col_pipe_d    = '0;
    vld_pipe_d[0] = accept;
    row_pipe_d[0] = accept ? row_q : '0;
    col_pipe_d[0] = accept ? col_q : '0;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      row_pipe_d[i] = row_pipe_q[i-1];
      col_pipe_d[i] = col_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      mode_q     <= 1'b0;
      vld_pipe_q <= '0;
      row_pipe_q <= '0;
      col_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      mode_q     <= mode_d;
      vld_pipe_q <= vld_pipe_d;
      row_pipe_q <= row_pipe_d;
      col_pipe_q <= col_pipe_d;
    end
  end

  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign rd_valid = (state_q == RUN);
  assign rd_row   = row_q;
  assign rd_col   = col_q;
  assign rd_last  = (state_q == RUN) && at_last;
  assign wr_valid = vld_pipe_q[READ_LATENCY-1];
  assign wr_row   = row_pipe_q[READ_LATENCY-1];
  assign wr_col   = col_pipe_q[READ_LATENCY-1];

`ifdef GCN_SEQ_STALL_COUNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start)
      stall_d = '0;
    else if (state_q == RUN && !rd_ready && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_gcn_index_sequencer.sv
// Directed bench: 6x3 sweeps in both orders, backpressure, mid-sweep reset, held start,
// plus a 1x1 instance for the single-element case.
module tb_gcn_index_sequencer;
  localparam int LAT = 2;
  localparam int N   = 18;

  logic clk = 1'b0;
  logic reset, start, col_major, rd_ready;
  logic busy, done, rd_valid, rd_last, wr_valid;
  logic [2:0] rd_row, wr_row;
  logic [1:0] rd_col, wr_col;
  logic s_start, s_ready;
  logic s_busy, s_done, s_rd_valid, s_rd_last, s_wr_valid;
  logic [0:0] s_rd_row, s_rd_col, s_wr_row, s_wr_col;
`ifdef GCN_SEQ_STALL_COUNT_EN
  logic [15:0] stall_count, s_stall_count;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  gcn_index_sequencer #(.ROWS(6), .COLS(3), .READ_LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .start(start), .col_major(col_major), .rd_ready(rd_ready),
    .busy(busy), .done(done), .rd_valid(rd_valid), .rd_row(rd_row), .rd_col(rd_col),
    .rd_last(rd_last), .wr_valid(wr_valid), .wr_row(wr_row), .wr_col(wr_col)
`ifdef GCN_SEQ_STALL_COUNT_EN
    , .stall_count(stall_count)
`endif
  );

  gcn_index_sequencer #(.ROWS(1), .COLS(1), .READ_LATENCY(LAT)) u_one (
    .clk(clk), .reset(reset), .start(s_start), .col_major(col_major), .rd_ready(s_ready),
    .busy(s_busy), .done(s_done), .rd_valid(s_rd_valid), .rd_row(s_rd_row), .rd_col(s_rd_col),
    .rd_last(s_rd_last), .wr_valid(s_wr_valid), .wr_row(s_wr_row), .wr_col(s_wr_col)
`ifdef GCN_SEQ_STALL_COUNT_EN
    , .stall_count(s_stall_count)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected element k of the sweep in the given order.
  task automatic idx(input int k, input bit cm, output int r, output int c);
    if (!cm) begin r = k / 3; c = k % 3; end
    else     begin r = k % 6; c = k / 6; end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; rd_ready = 1'b0; s_start = 1'b0; s_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic sweep(input bit cm, input bit tog, input bit hold, input int exp_busy);
    bit ev [0:255];
    int er [0:255];
    int ec [0:255];
    int k, cyc, busy_n, last_wr, r, c;
    bit rdy;
    for (int i = 0; i < 256; i++) begin ev[i] = 1'b0; er[i] = 0; ec[i] = 0; end
    start = 1'b1; col_major = cm; rd_ready = 1'b0;
    step();
    if (!hold) start = 1'b0;
    col_major = ~cm;
    k = 0; cyc = 0; busy_n = 0; last_wr = -10;
    forever begin
      rdy = tog ? (cyc % 2 == 0) : 1'b1;
      rd_ready = rdy;
      if (busy) busy_n++;
      if (k == N && cyc == last_wr + 1) begin
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 0);
        break;
      end
      chk("done_early", done, 0);
      chk("rd_valid", rd_valid, (k < N) ? 1 : 0);
      if (k < N) begin
        idx(k, cm, r, c);
        chk("rd_row", rd_row, r);
        chk("rd_col", rd_col, c);
        chk("rd_last", rd_last, (k == N - 1) ? 1 : 0);
        if (rdy) begin
          ev[cyc+LAT] = 1'b1; er[cyc+LAT] = r; ec[cyc+LAT] = c;
          if (k == N - 1) last_wr = cyc + LAT;
          k++;
        end
      end
      chk("wr_valid", wr_valid, ev[cyc]);
      if (ev[cyc]) begin
        chk("wr_row", wr_row, er[cyc]);
        chk("wr_col", wr_col, ec[cyc]);
      end
      cyc++;
      if (cyc > 250) begin
        chk("sweep_timeout", 0, 1);
        break;
      end
      step();
    end
    chk("busy_cycles", busy_n, exp_busy);
`ifdef GCN_SEQ_STALL_COUNT_EN
    chk("stall_count", stall_count, tog ? N - 1 : 0);
`endif
    step();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_rd_valid", rd_valid, 0);
`ifdef GCN_SEQ_STALL_COUNT_EN
    chk("stall_hold", stall_count, tog ? N - 1 : 0);
`endif
    if (hold) begin
      step();
      chk("restart_busy", busy, 1);
      chk("restart_idx", {rd_valid, rd_row, rd_col}, 32);
      start = 1'b0;
    end
  endtask

  initial begin
    col_major = 1'b0;
    do_reset();
    chk("reset_outs", {busy, done, rd_valid, rd_row, rd_col, rd_last, wr_valid, wr_row, wr_col}, 0);
    chk("reset_one", {s_busy, s_done, s_rd_valid, s_rd_last, s_wr_valid}, 0);

    sweep(1'b0, 1'b0, 1'b0, 20);
    sweep(1'b1, 1'b0, 1'b0, 20);
    sweep(1'b0, 1'b1, 1'b0, 37);

    // Mid-sweep reset at element (3,1) = index 10.
    start = 1'b1; col_major = 1'b0; rd_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("pre_rst_idx", {rd_row, rd_col}, 13);
    reset = 1'b1;
    #1;
    chk("async_rst_outs", {busy, done, rd_valid, rd_row, rd_col, rd_last, wr_valid, wr_row, wr_col}, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_done", done, 0);
    end
    reset = 1'b0;
    step();
    chk("post_rst_done", done, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("post_rst_start", {rd_valid, rd_row, rd_col}, 32);
    do_reset();

    sweep(1'b0, 1'b0, 1'b1, 20);
    do_reset();

    // 1x1 instance: single element, write LAT cycles later, done one cycle after.
    s_start = 1'b1; s_ready = 1'b1;
    step();
    s_start = 1'b0;
    chk("one_rd", {s_rd_valid, s_rd_last, s_rd_row, s_rd_col}, 12);
    step();
    chk("one_rd_gone", {s_rd_valid, s_wr_valid, s_busy}, 1);
    step();
    chk("one_wr", {s_wr_valid, s_wr_row, s_wr_col, s_done}, 8);
    step();
    chk("one_done", {s_done, s_busy, s_wr_valid}, 4);
    step();
    chk("one_idle", {s_done, s_busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
